neopixel_rx: RTL and testbench

NEOPIXEL_RX -- requirements
Module: neopixel_rx

---
 rtl/neopixel_pkg.sv | 31 +++
 rtl/sync2.sv | 25 ++
 rtl/neopixel_rx.sv | 170 +++++++++++++++++
 tb/tb_neopixel_rx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared NeoPixel definitions: line-decoder state enum, default WS2812 timing
// at 50 MHz, counter widths and a saturating frame-counter helper.
package neopixel_pkg;

    // Default timing in 50 MHz clocks
    localparam int unsigned T_THRESH_DEF     = 30;
    localparam int unsigned T_MIN_HIGH_DEF   = 8;
    localparam int unsigned T_MAX_HIGH_DEF   = 55;
    localparam int unsigned LATCH_CYCLES_DEF = 2500;

    // Counter and field widths
    localparam int unsigned HIGH_CNT_W  = 6;
    localparam int unsigned LOW_CNT_W   = 12;
    localparam int unsigned PIXEL_W     = 24;
    localparam int unsigned BIT_CNT_W   = 5;
    localparam int unsigned INDEX_W     = 4;
    localparam int unsigned FRAME_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } neo_state_e;

    // Pixel-per-frame count, sticks at its maximum
    function automatic logic [FRAME_CNT_W-1:0] frame_cnt_inc(input logic [FRAME_CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + FRAME_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clock, reset (async, active high), d_i (async in), q_o (synchronized out).
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/neopixel_rx.sv
// WS2812 single-wire receiver: measures high-pulse widths on the synchronized
// line, assembles 24-bit GRB pixels MSB-first and reports frame latches.
// Ports:
//   clock, reset      - 50 MHz clock, async active-high reset
//   neo_data          - asynchronous serial line
//   pixel_data/_index - last decoded pixel and its position in the frame (mod 16)
//   pixel_valid       - one-cycle pulse with each new pixel
//   frame_done        - one-cycle pulse on latch after >= 1 complete pixel
//   frame_pixels      - pixels in the frame just ended (saturating), held
//   bit_error         - one-cycle pulse on any protocol violation
module neopixel_rx
    import neopixel_pkg::*;
#(
    parameter int unsigned T_THRESH     = T_THRESH_DEF,
    parameter int unsigned T_MIN_HIGH   = T_MIN_HIGH_DEF,
    parameter int unsigned T_MAX_HIGH   = T_MAX_HIGH_DEF,
    parameter int unsigned LATCH_CYCLES = LATCH_CYCLES_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   neo_data,
    output logic [PIXEL_W-1:0]     pixel_data,
    output logic [INDEX_W-1:0]     pixel_index,
    output logic                   pixel_valid,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_pixels,
    output logic                   bit_error
);

    localparam logic [HIGH_CNT_W-1:0] THRESH_C     = HIGH_CNT_W'(T_THRESH);
    localparam logic [HIGH_CNT_W-1:0] MIN_HIGH_C   = HIGH_CNT_W'(T_MIN_HIGH);
    localparam logic [HIGH_CNT_W-1:0] MAX_HIGH_C   = HIGH_CNT_W'(T_MAX_HIGH);
    localparam logic [LOW_CNT_W-1:0]  LATCH_LAST_C = LOW_CNT_W'(LATCH_CYCLES - 1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT_C   = BIT_CNT_W'(PIXEL_W - 1);

    logic                   din;
    logic                   din_prev_q;
    neo_state_e             state_q;
    logic [HIGH_CNT_W-1:0]  high_cnt_q;
    logic [LOW_CNT_W-1:0]   low_cnt_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [PIXEL_W-2:0]     shift_q;
    logic [INDEX_W-1:0]     pix_idx_q;
    logic [FRAME_CNT_W-1:0] pix_cnt_q;

    logic                   bit_val_c;
    logic [PIXEL_W-1:0]     shift_next_c;

    sync2 u_sync2 (
        .clock (clock),
        .reset (reset),
        .d_i   (neo_data),
        .q_o   (din)
    );

    // Bit value and shift-register contents if the current high pulse ends now
    assign bit_val_c    = (high_cnt_q >= THRESH_C);
    assign shift_next_c = {shift_q, bit_val_c};

    // Line decoder FSM with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HUNT;
            din_prev_q   <= 1'b0;
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            pix_idx_q    <= '0;
            pix_cnt_q    <= '0;
            pixel_data   <= '0;
            pixel_index  <= '0;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            bit_error    <= 1'b0;
        end else begin
            din_prev_q  <= din;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_error   <= 1'b0;

            case (state_q)
                // Wait for a full latch-length low before trusting the line
                ST_HUNT: begin
                    if (din) begin
                        low_cnt_q <= '0;
                    end else if (low_cnt_q == LATCH_LAST_C) begin
                        state_q     <= ST_IDLE;
                        low_cnt_q   <= '0;
                        bit_cnt_q   <= '0;
                        pix_idx_q   <= '0;
                        pix_cnt_q   <= '0;
                        pixel_index <= '0;
                    end else begin
                        low_cnt_q <= low_cnt_q + LOW_CNT_W'(1);
                    end
                end

                ST_IDLE: begin
                    if (din && !din_prev_q) begin
                        state_q    <= ST_HIGH;
                        high_cnt_q <= HIGH_CNT_W'(1);
                    end
                end

                ST_HIGH: begin
                    if (din) begin
                        // Another high sample would push the pulse past the legal maximum
                        if (high_cnt_q >= MAX_HIGH_C) begin
                            bit_error <= 1'b1;
                            bit_cnt_q <= '0;
                            low_cnt_q <= '0;
                            state_q   <= ST_HUNT;
                        end else if (high_cnt_q != '1) begin
                            high_cnt_q <= high_cnt_q + HIGH_CNT_W'(1);
                        end
                    end else if (high_cnt_q < MIN_HIGH_C) begin
                        // Runt pulse; this low sample already counts toward resync
                        bit_error <= 1'b1;
                        bit_cnt_q <= '0;
                        low_cnt_q <= LOW_CNT_W'(1);
                        state_q   <= ST_HUNT;
                    end else begin
                        shift_q   <= shift_next_c[PIXEL_W-2:0];
                        low_cnt_q <= LOW_CNT_W'(1);
                        state_q   <= ST_LOW;
                        if (bit_cnt_q == LAST_BIT_C) begin
                            pixel_data  <= shift_next_c;
                            pixel_index <= pix_idx_q;
                            pixel_valid <= 1'b1;
                            pix_idx_q   <= pix_idx_q + INDEX_W'(1);
                            pix_cnt_q   <= frame_cnt_inc(pix_cnt_q);
                            bit_cnt_q   <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end

                ST_LOW: begin
                    if (din) begin
                        state_q    <= ST_HIGH;
                        high_cnt_q <= HIGH_CNT_W'(1);
                        low_cnt_q  <= '0;
                    end else if (low_cnt_q == LATCH_LAST_C) begin
                        // Latch: close the frame or flag a truncated pixel
                        if (bit_cnt_q != '0) begin
                            bit_error <= 1'b1;
                        end else if (pix_cnt_q != '0) begin
                            frame_done   <= 1'b1;
                            frame_pixels <= pix_cnt_q;
                        end
                        state_q     <= ST_IDLE;
                        low_cnt_q   <= '0;
                        bit_cnt_q   <= '0;
                        pix_idx_q   <= '0;
                        pix_cnt_q   <= '0;
                        pixel_index <= '0;
                    end else begin
                        low_cnt_q <= low_cnt_q + LOW_CNT_W'(1);
                    end
                end

                default: state_q <= ST_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_rx.sv
// Self-checking bench for neopixel_rx: drives the line as a sequence of
// high/low segments and predicts pixel, frame and error events from pulse
// widths and low-run lengths.
module tb_neopixel_rx;

    localparam int LATCH = 2500;
    localparam int T_MIN = 8;
    localparam int T_MAX = 55;
    localparam int T_TH  = 30;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        neo_data = 1'b0;
    logic [23:0] pixel_data;
    logic [3:0]  pixel_index;
    logic        pixel_valid;
    logic        frame_done;
    logic [4:0]  frame_pixels;
    logic        bit_error;

    neopixel_rx dut (
        .clock        (clock),
        .reset        (reset),
        .neo_data     (neo_data),
        .pixel_data   (pixel_data),
        .pixel_index  (pixel_index),
        .pixel_valid  (pixel_valid),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .bit_error    (bit_error)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic [23:0] data; logic [3:0] idx; int cyc; } pix_ev_t;
    typedef struct { logic [4:0] n; int cyc; } frm_ev_t;

    pix_ev_t exp_pix[$];
    pix_ev_t obs_pix[$];
    frm_ev_t exp_frm[$];
    frm_ev_t obs_frm[$];
    int exp_err = 0;
    int obs_err = 0;
    int n_cmp   = 0;
    int n_bad   = 0;

    // Reference model state
    bit          synced    = 1'b0;
    bit          active    = 1'b0;
    int          bits      = 0;
    int          pixels    = 0;
    int          low_run   = 0;
    int          low_start = 0;
    logic [23:0] cur       = '0;
    logic [23:0] last_pix  = '0;
    logic [4:0]  exp_fp    = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Event monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (pixel_valid) obs_pix.push_back('{pixel_data, pixel_index, cyc});
            if (frame_done) begin
                obs_frm.push_back('{frame_pixels, cyc});
                chk("frame_done exclusive", 64'({bit_error, pixel_valid}), 64'h0);
            end
            if (bit_error) obs_err++;
        end
    end

    task automatic model_clear();
        active = 1'b0;
        bits   = 0;
        pixels = 0;
    endtask

    // A complete high pulse of n clocks whose falling edge is driven at cycle c_fall
    task automatic model_high(input int n, input int c_fall);
        if (!synced) return;
        if (n < T_MIN || n > T_MAX) begin
            exp_err++;
            synced = 1'b0;
            model_clear();
            return;
        end
        cur    = {cur[22:0], (n >= T_TH)};
        bits   = bits + 1;
        active = 1'b1;
        if (bits == 24) begin
            exp_pix.push_back('{cur, 4'(pixels % 16), c_fall + 3});
            last_pix = cur;
            pixels   = pixels + 1;
            bits     = 0;
        end
    endtask

    // Low run has just reached latch length; low began being driven at c_start
    task automatic model_latch(input int c_start);
        if (!synced) begin
            synced = 1'b1;
            model_clear();
        end else if (active) begin
            if (bits != 0) begin
                exp_err++;
            end else begin
                exp_fp = (pixels > 31) ? 5'd31 : 5'(pixels);
                exp_frm.push_back('{exp_fp, c_start + 2 + LATCH});
            end
            model_clear();
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        if (lvl) begin
            model_high(n, cyc + n);
            low_run = 0;
        end else begin
            if (low_run == 0) low_start = cyc;
            if (low_run < LATCH && low_run + n >= LATCH) model_latch(low_start);
            low_run = low_run + n;
        end
        neo_data = lvl;
        repeat (n) @(negedge clock);
    endtask

    // mode 0: random legal widths, 1: 40/22 and 20/42, 2: 30 vs 29, 3: 55 vs 8
    task automatic send_bits(input logic [23:0] value, input int nbits, input int mode);
        for (int i = 23; i > 23 - nbits; i--) begin
            logic b;
            int   hi;
            int   lo;
            b  = value[i];
            lo = int'($urandom_range(30, 6));
            case (mode)
                1:       begin hi = b ? 40 : 20; lo = b ? 22 : 42; end
                2:       hi = b ? 30 : 29;
                3:       hi = b ? 55 : 8;
                default: hi = b ? int'($urandom_range(55, 30)) : int'($urandom_range(29, 8));
            endcase
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    task automatic check_events(input string tag);
        int np;
        int nf;
        #1;
        chk({tag, " pixel count"}, 64'(obs_pix.size()), 64'(exp_pix.size()));
        np = (obs_pix.size() < exp_pix.size()) ? obs_pix.size() : exp_pix.size();
        for (int i = 0; i < np; i++) begin
            chk({tag, " pixel data"},  64'(obs_pix[i].data), 64'(exp_pix[i].data));
            chk({tag, " pixel index"}, 64'(obs_pix[i].idx),  64'(exp_pix[i].idx));
            chk({tag, " pixel cycle"}, 64'(obs_pix[i].cyc),  64'(exp_pix[i].cyc));
        end
        chk({tag, " frame count"}, 64'(obs_frm.size()), 64'(exp_frm.size()));
        nf = (obs_frm.size() < exp_frm.size()) ? obs_frm.size() : exp_frm.size();
        for (int i = 0; i < nf; i++) begin
            chk({tag, " frame pixels"}, 64'(obs_frm[i].n),   64'(exp_frm[i].n));
            chk({tag, " frame cycle"},  64'(obs_frm[i].cyc), 64'(exp_frm[i].cyc));
        end
        chk({tag, " bit_error count"}, 64'(obs_err), 64'(exp_err));
        chk({tag, " pixel_data hold"}, 64'(pixel_data), 64'(last_pix));
        chk({tag, " frame_pixels hold"}, 64'(frame_pixels), 64'(exp_fp));
        obs_pix.delete();
        exp_pix.delete();
        obs_frm.delete();
        exp_frm.delete();
        obs_err = 0;
        exp_err = 0;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        neo_data = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset pixel_data",   64'(pixel_data),   64'h0);
        chk("reset pixel_index",  64'(pixel_index),  64'h0);
        chk("reset frame_pixels", 64'(frame_pixels), 64'h0);
        chk("reset pulses", 64'({pixel_valid, frame_done, bit_error}), 64'h0);
        reset    = 1'b0;
        synced   = 1'b0;
        model_clear();
        low_run  = 0;
        last_pix = '0;
        exp_fp   = '0;
    endtask

    initial begin
        apply_reset();
        drive(1'b0, 2600);
        check_events("boot");

        // Single known pixel with nominal WS2812 timing
        send_bits(24'hA5C30F, 24, 1);
        drive(1'b0, 2500);
        check_events("single");

        // Eight back-to-back pixels
        for (int p = 1; p <= 8; p++) send_bits(24'(p), 24, 0);
        drive(1'b0, 2600);
        check_events("eight");

        // Threshold and legal-extreme pulse widths
        send_bits(24'($urandom), 24, 2);
        send_bits(24'($urandom), 24, 3);
        drive(1'b0, 2600);
        check_events("widths");

        // Runt pulse from idle, then resync
        drive(1'b1, 7);
        drive(1'b0, 2600);
        check_events("runt");

        // Over-long pulse mid-frame discards the frame
        send_bits(24'($urandom), 24, 0);
        send_bits(24'($urandom), 3, 0);
        drive(1'b1, 56);
        drive(1'b0, 2600);
        check_events("overlong");

        // Truncated pixel at latch, then a clean frame
        send_bits(24'($urandom), 12, 0);
        drive(1'b0, 2600);
        check_events("truncated");
        send_bits(24'($urandom), 24, 0);
        send_bits(24'($urandom), 24, 0);
        drive(1'b0, 2600);
        check_events("after truncated");

        // Index wrap within a long frame
        for (int p = 0; p < 18; p++) send_bits(24'($urandom), 24, 0);
        drive(1'b0, 2600);
        check_events("wrap");

        // Reset in the middle of bit 10 of a pixel
        send_bits(24'($urandom), 24, 0);
        send_bits(24'($urandom), 10, 0);
        check_events("pre-reset");
        neo_data = 1'b1;
        repeat (12) @(negedge clock);
        apply_reset();
        drive(1'b0, 1000);
        send_bits(24'($urandom), 24, 0);
        check_events("unsynced");
        drive(1'b0, 2600);
        send_bits(24'($urandom), 24, 0);
        drive(1'b0, 2600);
        check_events("resynced");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(64'd5_000_000);
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule
